// File: rtl/samp_gen_pkg.sv
// Shared definitions for the multi-channel sample generator: FSM state codes
// and small constant helpers used by the top and the pacer.
package samp_gen_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RD   = 2'd2;
   localparam logic [1:0] ST_CAP  = 2'd3;

   // Index width for n items, never narrower than one bit.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   function automatic logic [31:0] nz1(input logic [31:0] v);
      return (v == 32'd0) ? 32'd1 : v;
   endfunction

endpackage

// File: rtl/samp_pacer.sv
// Two-stage period timer: prescale counter produces ticks, speed counter
// counts ticks; period is a one-cycle strobe every prescale'*speed' cycles.
module samp_pacer
   import samp_gen_pkg::*;
#(
   parameter int PRE_W = 16,
   parameter int SPD_W = 16
)(
   input  logic             clk_samp,
   input  logic             rst_clk_samp,
   input  logic             run,
   input  logic [PRE_W-1:0] prescale,
   input  logic [SPD_W-1:0] speed,
   output logic             period
);

   logic [PRE_W-1:0] r_pre_cnt;
   logic [SPD_W-1:0] r_spd_cnt;
   logic [PRE_W-1:0] w_pre_max;
   logic [SPD_W-1:0] w_spd_max;
   logic             w_tick;

   assign w_pre_max = PRE_W'(nz1(32'(prescale)) - 32'd1);
   assign w_spd_max = SPD_W'(nz1(32'(speed)) - 32'd1);

   // >= rather than == : limits may shrink at a wrap while a count is in flight.
   assign w_tick = run && (r_pre_cnt >= w_pre_max);
   assign period = w_tick && (r_spd_cnt >= w_spd_max);

   // NOTE: non-blocking assignments for all clocked state, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_samp or posedge rst_clk_samp) begin
      if (rst_clk_samp) begin
         r_pre_cnt <= '0;
         r_spd_cnt <= '0;
      end else if (!run) begin
         r_pre_cnt <= '0;
         r_spd_cnt <= '0;
      end else begin
         r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
         if (w_tick)
            r_spd_cnt <= period ? '0 : r_spd_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/samp_gen_mc.sv
// Multi-channel sample generator: once per sample period reads one word per
// channel from the sample RAM and presents it with a valid strobe.
module samp_gen_mc
   import samp_gen_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CH_W   = clog2(NUM_CH),
   parameter int SAMP_W = 10,
   parameter int DATA_W = 16,
   parameter int PRE_W  = 16,
   parameter int SPD_W  = 16
)(
   input  logic                   clk_samp,
   input  logic                   rst_clk_samp,
   input  logic                   en,
   input  logic                   one_shot,
   input  logic [SAMP_W:0]        nsamp,
   input  logic [PRE_W-1:0]       prescale,
   input  logic [SPD_W-1:0]       speed,
   output logic [CH_W+SAMP_W-1:0] ram_addr,
   output logic                   ram_rd_en,
   input  logic [DATA_W-1:0]      ram_data,
   output logic                   samp_val,
   output logic [CH_W-1:0]        samp_ch,
   output logic [DATA_W-1:0]      samp,
   output logic                   busy,
   output logic                   done
);

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   logic [1:0]        r_state, w_next;
   logic [CH_W-1:0]   r_ch;
   logic [SAMP_W-1:0] r_idx;
   logic [SAMP_W:0]   r_nsamp_l;
   logic [PRE_W-1:0]  r_pre_l;
   logic [SPD_W-1:0]  r_spd_l;
   logic              r_one_shot_l;
   logic              r_pend, r_stop;
   logic              r_samp_val;
   logic [CH_W-1:0]   r_samp_ch;
   logic [DATA_W-1:0] r_samp;
   logic              w_period, w_run, w_start, w_last_ch, w_last_idx;

   assign w_run      = (r_state != ST_IDLE);
   assign w_start    = en && (nsamp != '0);
   assign w_last_ch  = (r_ch == LAST_CH);
   assign w_last_idx = (({1'b0, r_idx} + 1'b1) == r_nsamp_l);

   samp_pacer #(.PRE_W(PRE_W), .SPD_W(SPD_W)) u_pacer (
      .clk_samp     (clk_samp),
      .rst_clk_samp (rst_clk_samp),
      .run          (w_run),
      .prescale     (r_pre_l),
      .speed        (r_spd_l),
      .period       (w_period)
   );

   always_ff @(posedge clk_samp or posedge rst_clk_samp) begin
      if (rst_clk_samp) r_state <= ST_IDLE;
      else              r_state <= w_next;
   end

   // A period that lands inside a burst (r_pend) chains straight into the next
   // burst, so short periods stretch to exactly the burst length.
   always_comb begin
      // NOTE: default first so no path through the case leaves w_next unassigned
      // (that would infer a latch).
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_start) w_next = ST_WAIT;
         ST_WAIT: begin
            if (!en)           w_next = ST_IDLE;
            else if (w_period) w_next = ST_RD;
         end
         ST_RD:   w_next = ST_CAP;
         ST_CAP: begin
            if (!w_last_ch)                      w_next = ST_RD;
            else if (w_last_idx && r_one_shot_l) w_next = ST_IDLE;
            else if (r_stop || !en)              w_next = ST_IDLE;
            else if (w_period || r_pend)         w_next = ST_RD;
            else                                 w_next = ST_WAIT;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      ram_rd_en = 1'b0;
      ram_addr  = '0;
      done      = 1'b0;
      if (r_state == ST_RD) begin
         ram_rd_en = 1'b1;
         ram_addr  = {r_ch, r_idx};
      end
      if ((r_state == ST_CAP) && w_last_ch && w_last_idx && r_one_shot_l)
         done = 1'b1;
   end

   always_ff @(posedge clk_samp or posedge rst_clk_samp) begin
      if (rst_clk_samp) begin
         r_ch         <= '0;
         r_idx        <= '0;
         r_nsamp_l    <= '0;
         r_pre_l      <= '0;
         r_spd_l      <= '0;
         r_one_shot_l <= 1'b0;
         r_pend       <= 1'b0;
         r_stop       <= 1'b0;
         r_samp_val   <= 1'b0;
         r_samp_ch    <= '0;
         r_samp       <= '0;
      end else begin
         r_samp_val <= (r_state == ST_CAP);
         case (r_state)
            ST_IDLE: begin
               r_pend <= 1'b0;
               r_stop <= 1'b0;
               if (w_start) begin
                  r_nsamp_l    <= nsamp;
                  r_pre_l      <= prescale;
                  r_spd_l      <= speed;
                  r_one_shot_l <= one_shot;
                  r_idx        <= '0;
                  r_ch         <= '0;
               end
            end
            ST_WAIT: begin
               r_pend <= 1'b0;
               r_stop <= 1'b0;
            end
            ST_RD: begin
               r_pend <= r_pend | w_period;
               r_stop <= r_stop | ~en;
            end
            ST_CAP: begin
               r_samp    <= ram_data;
               r_samp_ch <= r_ch;
               if (!w_last_ch) begin
                  r_ch   <= r_ch + 1'b1;
                  r_pend <= r_pend | w_period;
                  r_stop <= r_stop | ~en;
               end else begin
                  r_ch   <= '0;
                  r_pend <= 1'b0;
                  r_stop <= 1'b0;
                  if (!w_last_idx) begin
                     r_idx <= r_idx + 1'b1;
                  end else begin
                     r_idx <= '0;
                     // Continuous wrap: new pacing applies from the next pass.
                     if (!r_one_shot_l) begin
                        r_pre_l <= prescale;
                        r_spd_l <= speed;
                        if (nsamp != '0) r_nsamp_l <= nsamp;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy     = w_run;
   assign samp_val = r_samp_val;
   assign samp_ch  = r_samp_ch;
   assign samp     = r_samp;

endmodule

// File: tb/tb_samp_gen_mc.sv
// Self-checking bench for samp_gen_mc: table of one-shot runs plus hand-written
// continuous, idle, early-stop and reset sequences, scored against a queue.
module tb_samp_gen_mc;

   localparam int NUM_CH = 2;
   localparam int CH_W   = 1;
   localparam int SAMP_W = 10;
   localparam int DATA_W = 16;

   logic                   clk_samp, rst_clk_samp;
   logic                   en, one_shot;
   logic [SAMP_W:0]        nsamp;
   logic [15:0]            prescale, speed;
   logic [CH_W+SAMP_W-1:0] ram_addr;
   logic                   ram_rd_en;
   logic [DATA_W-1:0]      ram_data;
   logic                   samp_val;
   logic [CH_W-1:0]        samp_ch;
   logic [DATA_W-1:0]      samp;
   logic                   busy, done;

   samp_gen_mc #(.NUM_CH(NUM_CH), .CH_W(CH_W), .SAMP_W(SAMP_W), .DATA_W(DATA_W),
                 .PRE_W(16), .SPD_W(16)) dut (
      .clk_samp     (clk_samp),
      .rst_clk_samp (rst_clk_samp),
      .en           (en),
      .one_shot     (one_shot),
      .nsamp        (nsamp),
      .prescale     (prescale),
      .speed        (speed),
      .ram_addr     (ram_addr),
      .ram_rd_en    (ram_rd_en),
      .ram_data     (ram_data),
      .samp_val     (samp_val),
      .samp_ch      (samp_ch),
      .samp         (samp),
      .busy         (busy),
      .done         (done)
   );

   initial begin
      clk_samp = 1'b0;
      forever #5 clk_samp = ~clk_samp;
   end

   // Sample RAM: word = address + 0x100, one cycle read latency.
   always @(posedge clk_samp)
      if (ram_rd_en) ram_data <= 16'(ram_addr) + 16'h100;

   int cyc = 0;
   always @(posedge clk_samp) cyc <= cyc + 1;

   typedef struct {
      bit os;
      int nsamp, pre, spd;
      int first, per;   // expected: en-to-first-sample cycles, burst-to-burst cycles
   } row_t;

   typedef struct {
      int ch, val, cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0, n_pass = 0;
   int   rd_cnt = 0, busy_cnt = 0, done_cnt = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int exp_val(input int ch, input int idx);
      return ch * 1024 + idx + 256;
   endfunction

   always @(negedge clk_samp) begin : mon
      exp_t e;
      if (!rst_clk_samp) begin
         if (ram_rd_en) rd_cnt++;
         if (busy)      busy_cnt++;
         if (done)      done_cnt++;
         if (samp_val) begin
            if (sb.size() == 0) begin
               check("spurious_samp_val", sb.size(), 1);
            end else begin
               e = sb.pop_front();
               check("samp_ch",  samp_ch, e.ch);
               check("samp",     samp,    e.val);
               check("samp_cyc", cyc,     e.cyc);
            end
         end
      end
   end

   task automatic push_pair(input int idx, input int t);
      sb.push_back('{ch: 0, val: exp_val(0, idx), cyc: t});
      sb.push_back('{ch: 1, val: exp_val(1, idx), cyc: t + 2});
   endtask

   task automatic run_row(input row_t r);
      int c0, d0, last_t;
      bit got;
      @(negedge clk_samp);
      one_shot = r.os;
      nsamp    = (SAMP_W+1)'(r.nsamp);
      prescale = 16'(r.pre);
      speed    = 16'(r.spd);
      en       = 1'b1;
      c0 = cyc;
      d0 = done_cnt;
      for (int i = 0; i < r.nsamp; i++) push_pair(i, c0 + r.first + i * r.per);
      last_t = c0 + r.first + (r.nsamp - 1) * r.per + 2;
      got = 1'b0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk_samp);
         if (done) got = 1'b1;
      end
      en = 1'b0;
      check("done_seen", got, 1);
      check("done_cyc", cyc, last_t - 1);
      check("busy_at_done", busy, 1);
      @(negedge clk_samp);
      check("busy_after_done", busy, 0);
      repeat (3) @(negedge clk_samp);
      check("row_sb_empty", sb.size(), 0);
      check("row_done_count", done_cnt - d0, 1);
   endtask

   row_t rows[6];
   int   c0, d0, r0, b0;
   int   offs[5];
   int   idxs[5];

   initial begin
      rows[0] = '{os: 1, nsamp: 4, pre: 4, spd: 2, first: 11, per: 8};
      rows[1] = '{os: 1, nsamp: 3, pre: 0, spd: 0, first: 4,  per: 4};
      rows[2] = '{os: 1, nsamp: 1, pre: 1, spd: 1, first: 4,  per: 4};
      rows[3] = '{os: 1, nsamp: 2, pre: 2, spd: 2, first: 7,  per: 4};
      rows[4] = '{os: 1, nsamp: 2, pre: 3, spd: 0, first: 6,  per: 4};
      rows[5] = '{os: 1, nsamp: 2, pre: 0, spd: 5, first: 8,  per: 5};

      rst_clk_samp = 1'b1;
      en = 1'b0; one_shot = 1'b0; nsamp = '0; prescale = '0; speed = '0;
      repeat (3) @(negedge clk_samp);
      check("rst_samp_val", samp_val, 0);
      check("rst_samp",     samp,     0);
      check("rst_samp_ch",  samp_ch,  0);
      check("rst_busy",     busy,     0);
      check("rst_done",     done,     0);
      check("rst_rd_en",    ram_rd_en, 0);
      check("rst_addr",     ram_addr, 0);
      rst_clk_samp = 1'b0;
      repeat (2) @(negedge clk_samp);

      for (int i = 0; i < 6; i++) run_row(rows[i]);

      // Continuous pass of 3; speed change mid-pass applies only after the wrap.
      offs = '{11, 19, 27, 47, 67};
      idxs = '{0, 1, 2, 0, 1};
      @(negedge clk_samp);
      one_shot = 1'b0; nsamp = 11'd3; prescale = 16'd4; speed = 16'd2; en = 1'b1;
      c0 = cyc;
      d0 = done_cnt;
      for (int i = 0; i < 5; i++) push_pair(idxs[i], c0 + offs[i]);
      for (int i = 0; i < 69; i++) begin
         @(negedge clk_samp);
         if (cyc == c0 + 12) speed = 16'd5;
      end
      check("cont_busy_in_wait", busy, 1);
      en = 1'b0;
      @(negedge clk_samp);
      check("cont_idle_next", busy, 0);
      repeat (30) @(negedge clk_samp);
      check("cont_sb_empty", sb.size(), 0);
      check("cont_no_done", done_cnt - d0, 0);

      // nsamp=0 never starts.
      @(negedge clk_samp);
      one_shot = 1'b1; nsamp = '0; prescale = 16'd4; speed = 16'd2; en = 1'b1;
      r0 = rd_cnt;
      b0 = busy_cnt;
      repeat (1000) @(negedge clk_samp);
      en = 1'b0;
      check("nsamp0_rd_count", rd_cnt - r0, 0);
      check("nsamp0_busy_count", busy_cnt - b0, 0);

      // en dropped during the ch0 read: the burst still finishes, then IDLE.
      @(negedge clk_samp);
      one_shot = 1'b1; nsamp = 11'd4; prescale = 16'd4; speed = 16'd2; en = 1'b1;
      c0 = cyc;
      d0 = done_cnt;
      push_pair(0, c0 + 11);
      repeat (9) @(negedge clk_samp);
      check("stop_rd_en", ram_rd_en, 1);
      check("stop_rd_addr", ram_addr, 0);
      en = 1'b0;
      repeat (3) @(negedge clk_samp);
      check("stop_busy_last_cap", busy, 1);
      @(negedge clk_samp);
      check("stop_busy_idle", busy, 0);
      repeat (5) @(negedge clk_samp);
      check("stop_sb_empty", sb.size(), 0);
      check("stop_no_done", done_cnt - d0, 0);

      // Asynchronous reset between the ch1 read and its capture.
      @(negedge clk_samp);
      one_shot = 1'b1; nsamp = 11'd4; prescale = 16'd4; speed = 16'd2; en = 1'b1;
      c0 = cyc;
      sb.push_back('{ch: 0, val: exp_val(0, 0), cyc: c0 + 11});
      repeat (11) @(negedge clk_samp);
      #1;
      rst_clk_samp = 1'b1;
      #1;
      check("arst_samp_val", samp_val, 0);
      check("arst_samp",     samp,     0);
      check("arst_busy",     busy,     0);
      check("arst_rd_en",    ram_rd_en, 0);
      en = 1'b0;
      repeat (2) @(negedge clk_samp);
      rst_clk_samp = 1'b0;
      check("arst_sb_empty", sb.size(), 0);
      run_row('{os: 1, nsamp: 1, pre: 4, spd: 2, first: 11, per: 8});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
